// File: rtl/config_pkg.sv
// Shared configuration for the CSR peripherals: CSR decoder types, the
// CSR operation encoding and the UART transmitter address and baud divisor.
package config_pkg;

  typedef logic [11:0] CsrAddrT;
  typedef logic [31:0] word;
  typedef logic [4:0]  r;

  // RISC-V funct3 encoding of the Zicsr instructions.
  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSRRW    = 3'b001,
    CSRRS    = 3'b010,
    CSRRC    = 3'b011,
    CSRRWI   = 3'b101,
    CSRRSI   = 3'b110,
    CSRRCI   = 3'b111
  } csr_op_t;

  localparam CsrAddrT UartTxAddr  = 12'h7C1;
  localparam int      UartBaudDiv = 868;  // 100 MHz / 115200

endpackage

// File: rtl/uart_pkg.sv
// UART types shared by the transmitter and any future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/fifo_n.sv
// Generic synchronous FIFO with power-of-two depth. Pushes into a full FIFO
// are ignored even when a pop happens in the same cycle (full is judged on
// the state before the pop).
module fifo_n #(
  parameter int DataWidth = 8,
  parameter int Depth     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] din,
  output logic [DataWidth-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataWidth-1:0] mem [Depth];
  logic [AddrW-1:0]     wptr;
  logic [AddrW-1:0]     rptr;
  logic [AddrW:0]       count;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == (AddrW + 1)'(Depth));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo Depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/csr_uart_tx.sv
// CSR-mapped 8N1 UART transmitter. Writes (CSRRW/CSRRWI) to Addr queue a
// byte; reads return {overflow, full, busy}. A CSRRC with operand bit 2 set
// clears the sticky overflow flag.
// Build option: UART_TX_FIFO_EN selects a FifoDepth-entry FIFO (fifo_n)
// instead of the single holding register.
module csr_uart_tx
  import config_pkg::*;
  import uart_pkg::*;
#(
  parameter CsrAddrT Addr      = UartTxAddr,
  parameter int      BaudDiv   = UartBaudDiv,
  parameter int      FifoDepth = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    csr_enable,
  input  CsrAddrT csr_addr,
  input  csr_op_t csr_op,
  input  r        rs1_zimm,
  input  word     rs1_data,
  output word     csr_out,
  output logic    tx,
  output logic    busy
);

  localparam int             CntW      = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(BaudDiv - 1);

  uart_state_t     state;
  uart_state_t     state_next;
  logic [CntW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shifter;
  logic            overflow;

  logic            sel;
  logic            wr;
  logic            clr;
  logic            load;
  logic            cnt_zero;
  logic            avail;
  logic [7:0]      wr_byte;
  logic [7:0]      head;
  logic [7:0]      load_byte;
  logic            st_full;
  logic            st_empty;
  logic            push;
  logic            pop;
  logic            unused_rs1;

  // Writes in the reset cycle are discarded by gating the decode with reset.
  assign sel        = csr_enable && (csr_addr == Addr) && !reset;
  assign wr         = sel && (csr_op == CSRRW || csr_op == CSRRWI);
  assign clr        = sel && (csr_op == CSRRC) && rs1_data[2];
  assign wr_byte    = (csr_op == CSRRWI) ? {3'b000, rs1_zimm} : rs1_data[7:0];
  assign unused_rs1 = ^rs1_data[31:8];

  // An incoming write counts as available so an idle line starts the frame
  // on the very next cycle, bypassing storage when storage is empty.
  assign avail     = !st_empty || wr;
  assign load_byte = st_empty ? wr_byte : head;
  assign push      = wr && !st_full && !(load && st_empty);
  assign pop       = load && !st_empty;
  assign cnt_zero  = (cnt == '0);

  assign busy    = (state != IDLE) || !st_empty;
  assign csr_out = {29'd0, overflow, st_full, busy};

`ifdef UART_TX_FIFO_EN
  fifo_n #(
    .DataWidth (8),
    .Depth     (FifoDepth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (wr_byte),
    .dout  (head),
    .full  (st_full),
    .empty (st_empty)
  );
`else
  localparam int unused_depth = FifoDepth;

  logic       hold_valid;
  logic [7:0] hold_data;

  assign st_full  = hold_valid;
  assign st_empty = !hold_valid;
  assign head     = hold_data;

  // Single-byte holding register between the CSR write and the shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
    end else if (push) begin
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  // Holding register payload; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (push) hold_data <= wr_byte;
  end
`endif

  // Frame sequencing and line level: next state, shifter load and tx.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    tx         = 1'b1;
    unique case (state)
      IDLE: begin
        if (avail) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (cnt_zero) state_next = DATA;
      end
      DATA: begin
        tx = shifter[0];
        if (cnt_zero && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (cnt_zero) begin
          if (avail) begin
            load       = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, baud counter and bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        cnt     <= CntReload;
        bit_idx <= '0;
      end else if (state != IDLE) begin
        if (cnt_zero) begin
          cnt <= (state_next == IDLE) ? '0 : CntReload;
          if (state == DATA) bit_idx <= bit_idx + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Serial shifter, LSB first; payload only, so no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      shifter <= load_byte;
    end else if (state == DATA && cnt_zero) begin
      shifter <= {1'b0, shifter[7:1]};
    end
  end

  // Sticky overflow: a dropped write in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr && st_full) begin
      overflow <= 1'b1;
    end else if (clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/csr_uart_tx.md
CSR_UART_TX -- requirements
Module: csr_uart_tx

Interface
REQ-001 Parameter Addr, default UartTxAddr (config_pkg), CSR address decoded by the block.
REQ-002 Parameter BaudDiv, default 868, clock cycles per serial bit (100 MHz / 115200).
REQ-003 Parameter FifoDepth, default 4, transmit FIFO entries; power of two, at least 2; used only with UART_TX_FIFO_EN.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 csr_enable  input  1  decoder CSR instruction valid.
REQ-007 csr_addr  input  CsrAddrT  decoder CSR address.
REQ-008 csr_op  input  csr_op_t  decoder CSR operation.
REQ-009 rs1_zimm  input  r  rs1 index / 5-bit zero-extended immediate.
REQ-010 rs1_data  input  word  register file rs1 value.
REQ-011 csr_out  output  word  status read value: bit0 busy, bit1 full, bit2 overflow, others 0.
REQ-012 tx  output  1  serial line, idle high; drives the top-level rx pin.
REQ-013 busy  output  1  high while a frame is shifting or data is queued.

Function
REQ-014 Write strobe = csr_enable && csr_addr == Addr && csr_op in {CSRRW, CSRRWI}; other ops write nothing.
REQ-015 Written byte = rs1_data[7:0] for CSRRW; {3'b0, rs1_zimm} for CSRRWI.
REQ-016 csr_out combinational from current-cycle state; no side effect on read.
REQ-017 FSM states IDLE, START, DATA, STOP; frame 8N1, LSB first.
REQ-018 IDLE: tx=1; if a byte is available, load shifter and enter START next cycle.
REQ-019 START: tx=0 for BaudDiv cycles; DATA: 8 bits, BaudDiv cycles each; STOP: tx=1 for BaudDiv cycles.
REQ-020 Baud counter counts BaudDiv-1 down to 0; bit advances when counter is 0; width $clog2(BaudDiv).
REQ-021 From STOP end: go to START directly if another byte is available (no idle gap), else IDLE.
REQ-022 Frame length exactly 10*BaudDiv cycles; tx falls in the cycle after the accepting write edge when idle.
REQ-023 Write while full: byte dropped, overflow (sticky) set; the frame in flight is unaffected.
REQ-024 CSRRC to Addr with bit2 of its operand set clears overflow; a simultaneous overflow event wins (stays set).
REQ-025 full = no storage slot free; busy = state != IDLE || storage non-empty.

Reset
REQ-026 Reset, including mid-frame: state IDLE, tx=1, counter 0, storage empty, overflow 0, busy 0, csr_out 0.
REQ-027 A write in the reset cycle is ignored.

Configuration
REQ-028 UART_TX_FIFO_EN defined: FifoDepth-entry FIFO, pointers wrapping modulo FifoDepth, full at FifoDepth entries; simultaneous push and pop when full is a drop (full evaluated before the pop).
REQ-029 UART_TX_FIFO_EN undefined: single holding register; full whenever it holds a byte; otherwise identical behaviour.

Structure
REQ-030 config_pkg holds UartTxAddr and UartBaudDiv; uart_state_t enum in a shared uart_pkg.
REQ-031 FIFO is sub-module fifo_n (DataWidth, Depth; push, pop, full, empty), instantiated only under UART_TX_FIFO_EN.
REQ-032 Top-level integration: tx replaces csr_led_out MSB on the rx pin; csr_out added to the top-level CSR read mux for Addr.

Verification (bench BaudDiv=4, FifoDepth=4)
REQ-033 Reset then CSRRW 0x55 -> tx=0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; busy low at cycle 41.
REQ-034 CSRRWI zimm=0x1F -> data bits 1,1,1,1,1,0,0,0 LSB first.
REQ-035 Writes 0x01, 0x02 back to back -> two frames, second start bit immediately after first stop bit, 80 cycles total.
REQ-036 FIFO build: 6 writes while idle -> 5 frames sent (1 shifter + 4 queued), csr_out=0x7 after the 6th write; CSRRC operand 0x4 -> bit2 cleared.
REQ-037 Reset asserted 10 cycles into a frame -> tx=1 and csr_out=0 next cycle, no further frame.
REQ-038 CSRRS 0xAA to Addr and CSRRW to Addr+1 -> no frame, tx stays 1.
